serial_subtractor: RTL and testbench

//  Bit-serial N-bit subtractor: computes diff = a - b, LSB-first, one bit per clock.

---
 rtl/serial_subtractor.sv | 125 ++++++++++++
 tb/tb_serial_subtractor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, one full-subtractor cell,
// valid/ready handshakes on both the operand and the result side.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
  output logic             ovf_out,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
  logic [WIDTH-1:0] diff_out_q, diff_out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             borrow_out_q, borrow_out_d;
  logic             ovf_q, ovf_d;
  logic             d_bit;
  logic             b_out_bit;

  always_comb begin
    d_bit     = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
    b_out_bit = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & borrow_q);
  end

  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    diff_sh_d    = diff_sh_q;
    diff_out_d   = diff_out_q;
    cnt_d        = cnt_q;
    borrow_d     = borrow_q;
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    borrow_out_d = borrow_out_q;
    ovf_d        = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_sh_d    = a_in;
          b_sh_d    = b_in;
          a_msb_d   = a_in[WIDTH-1];
          b_msb_d   = b_in[WIDTH-1];
          diff_sh_d = '0;
          borrow_d  = 1'b0;
          cnt_d     = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        a_sh_d               = a_sh_q >> 1;
        b_sh_d               = b_sh_q >> 1;
        diff_sh_d            = diff_sh_q >> 1;
        diff_sh_d[WIDTH-1]   = d_bit;
        borrow_d             = b_out_bit;
        cnt_d                = cnt_q + 1'b1;
        // Last bit: publish the result registers only now so they stay frozen otherwise
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          diff_out_d   = diff_sh_d;
          borrow_out_d = b_out_bit;
          ovf_d        = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
          state_d      = DONE;
        end
      end
      DONE: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      diff_sh_q    <= '0;
      diff_out_q   <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      borrow_out_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      diff_sh_q    <= diff_sh_d;
      diff_out_q   <= diff_out_d;
      cnt_q        <= cnt_d;
      borrow_q     <= borrow_d;
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      borrow_out_q <= borrow_out_d;
      ovf_q        <= ovf_d;
    end
  end

  assign start_ready  = (state_q == IDLE);
  assign result_valid = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign diff_out     = diff_out_q;
  assign borrow_out   = borrow_out_q;
  assign ovf_out      = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: WIDTH=8 and WIDTH=1 instances, directed cases
// then a random valid/ready sweep checked against an arithmetic reference model.
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
    int         acc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       sv_r[2];
  logic       rr_r[2];
  logic [7:0] a_r[2];
  logic [7:0] b_r[2];
  logic [7:0] diff_o[2];
  logic       sr_o[2], rv_o[2], bo_o[2], ov_o[2], busy_o[2];
  logic [0:0] diff1;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   in_rst;
  bit   held[2], outst[2], cons_pend[2], acc_last[2];
  exp_t cur[2];
  exp_t exp_q[2][$];

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv_r[0]), .start_ready(sr_o[0]),
    .a_in(a_r[0]), .b_in(b_r[0]), .result_valid(rv_o[0]), .result_ready(rr_r[0]),
    .diff_out(diff_o[0]), .borrow_out(bo_o[0]), .ovf_out(ov_o[0]), .busy(busy_o[0])
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv_r[1]), .start_ready(sr_o[1]),
    .a_in(a_r[1][0:0]), .b_in(b_r[1][0:0]), .result_valid(rv_o[1]), .result_ready(rr_r[1]),
    .diff_out(diff1), .borrow_out(bo_o[1]), .ovf_out(ov_o[1]), .busy(busy_o[1])
  );

  assign diff_o[1] = {7'b0, diff1};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wOf(input int d);
    return (d == 0) ? 8 : 1;
  endfunction

  // Reference: plain integer arithmetic on the unsigned and signed readings of the operands
  function automatic exp_t refSub(input int w, input int a, input int b);
    exp_t e;
    int m, sa, sb, ideal;
    m      = 1 << w;
    sa     = (a >= m / 2) ? a - m : a;
    sb     = (b >= m / 2) ? b - m : b;
    ideal  = sa - sb;
    e.diff   = 8'((a - b + m) % m);
    e.borrow = (a < b);
    e.ovf    = (ideal < -(m / 2)) || (ideal > m / 2 - 1);
    e.acc    = 0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input int d, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s dut%0d: actual=%0h required=%0h at cycle %0d", name, d, act, exp, cyc);
    end
  endtask

  // One cycle of drive: inputs change on the falling edge, handshakes are decided before the rise
  task automatic applyStimulus(input int d, input bit sv, input int a, input int b, input bit rr);
    exp_t e;
    int   m;
    @(negedge clk);
    m        = (1 << wOf(d)) - 1;
    sv_r[d]  = sv;
    a_r[d]   = 8'(a & m);
    b_r[d]   = 8'(b & m);
    rr_r[d]  = rr;
    #1;
    acc_last[d] = sv && sr_o[d];
    if (acc_last[d]) begin
      e     = refSub(wOf(d), a & m, b & m);
      e.acc = cyc + 1;
      exp_q[d].push_back(e);
      outst[d] = 1'b1;
    end
    if (rv_o[d] && rr) begin
      cons_pend[d] = 1'b1;
      outst[d]     = 1'b0;
    end
  endtask

  task automatic monitorDut(input int d);
    if (cons_pend[d]) begin
      held[d]      = 1'b0;
      cons_pend[d] = 1'b0;
    end
    if (!held[d] && exp_q[d].size() > 0) begin
      if (cyc == exp_q[d][0].acc + wOf(d)) begin
        cur[d]  = exp_q[d].pop_front();
        held[d] = 1'b1;
      end
    end
    checkOutput("result_valid", d, rv_o[d], held[d]);
    checkOutput("start_ready", d, sr_o[d], !outst[d]);
    checkOutput("busy", d, busy_o[d], outst[d]);
    checkOutput("diff_out", d, diff_o[d], cur[d].diff);
    checkOutput("borrow_out", d, bo_o[d], cur[d].borrow);
    checkOutput("ovf_out", d, ov_o[d], cur[d].ovf);
  endtask

  always @(posedge clk) begin
    #1;
    if (!in_rst) begin
      monitorDut(0);
      monitorDut(1);
    end
  end

  task automatic doReset();
    in_rst = 1'b1;
    rst_n  = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput("rst_diff", d, diff_o[d], 0);
      checkOutput("rst_borrow", d, bo_o[d], 0);
      checkOutput("rst_ovf", d, ov_o[d], 0);
      checkOutput("rst_valid", d, rv_o[d], 0);
      checkOutput("rst_busy", d, busy_o[d], 0);
      exp_q[d].delete();
      held[d]      = 1'b0;
      outst[d]     = 1'b0;
      cons_pend[d] = 1'b0;
      cur[d]       = '{diff: 8'h00, borrow: 1'b0, ovf: 1'b0, acc: 0};
    end
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    in_rst = 1'b0;
  endtask

  task automatic runOp(input int d, input int a, input int b, input int hold, input bit noise,
                       input int e_diff, input int e_borrow, input int e_ovf);
    int n;
    n = 0;
    do begin
      applyStimulus(d, 1'b1, a, b, 1'b0);
      n++;
    end while (!acc_last[d] && n < 20);
    checkOutput("op_accepted", d, acc_last[d], 1);
    for (n = 0; n < 40; n++) begin
      applyStimulus(d, noise, $urandom, $urandom, 1'b0);
      if (rv_o[d]) break;
    end
    checkOutput("op_result_seen", d, rv_o[d], 1);
    checkOutput("op_diff", d, diff_o[d], e_diff);
    checkOutput("op_borrow", d, bo_o[d], e_borrow);
    checkOutput("op_ovf", d, ov_o[d], e_ovf);
    repeat (hold) applyStimulus(d, noise, $urandom, $urandom, 1'b0);
    applyStimulus(d, noise, $urandom, $urandom, 1'b1);
  endtask

  task automatic randomSweep(input int d, input int cycles);
    for (int i = 0; i < cycles; i++)
      applyStimulus(d, ($urandom % 4) != 0, $urandom, $urandom, $urandom_range(0, 1) == 1);
    repeat (30) applyStimulus(d, 1'b0, 0, 0, 1'b1);
    checkOutput("drained", d, exp_q[d].size() + int'(held[d]), 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      sv_r[d] = 1'b0;
      rr_r[d] = 1'b0;
      a_r[d]  = 8'h00;
      b_r[d]  = 8'h00;
    end
    rst_n = 1'b1;
    #2;
    doReset();

    runOp(0, 200, 55, 0, 1'b0, 145, 0, 0);
    runOp(0, 5, 10, 0, 1'b0, 8'hFB, 1, 0);
    runOp(0, 8'h3C, 8'h0F, 0, 1'b1, 8'h2D, 0, 0);
    runOp(0, 8'h80, 8'h01, 20, 1'b1, 8'h7F, 0, 1);

    // Abandon an operation a few RUN cycles in; its result must never appear
    do applyStimulus(0, 1'b1, 8'h12, 8'h34, 1'b0); while (!acc_last[0]);
    repeat (2) applyStimulus(0, 1'b0, 0, 0, 1'b1);
    #2;
    doReset();
    runOp(0, 8'hFF, 8'hFF, 0, 1'b0, 0, 0, 0);

    fork
      randomSweep(0, 3000);
      randomSweep(1, 3000);
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
